instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of the first word written.
REQ-003 Ports SHALL be exactly as follows; clock and reset are listed first:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid at a rising edge
- req_op  in  4  0 ADD, 1 SUB, 2 SLT, 3 MUL, 4 LW, 5 SW, 6 ADDI, 7 BEQ, 8 J; 9-15 illegal
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  16  immediate or branch offset
- req_target  in  26  jump target
- req_finish  in  1  end-of-program request
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  32  byte address of the write
- imem_wdata  out  32  encoded instruction word
- count  out  clog2(DEPTH+1)  number of words written
- full  out  1  count equals DEPTH
- done  out  1  program closed (sticky)
- err_illegal  out  1  illegal opcode seen (sticky)

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, ENC, WRITE, DONE.
REQ-005 req_ready SHALL equal (state==IDLE) & ~full & ~done.
REQ-006 In IDLE, a handshake SHALL capture all req_* fields and move the FSM to ENC.
REQ-007 In ENC, the FSM SHALL move to WRITE for a legal op.
REQ-008 In ENC, an illegal op SHALL set err_illegal, leave count unchanged and return the FSM to IDLE without a write.
REQ-009 R-type encoding (ADD/SUB/SLT/MUL) SHALL be: opcode 000000, rs[25:21], rt[20:16], rd[15:11], shamt 0, funct 100000/100010/101010/011100 respectively.
REQ-010 I-type encoding SHALL be: LW opcode 100011, SW 101011, ADDI 001000, BEQ 000100, with rs[25:21], rt[20:16], imm[15:0]; req_rd is ignored.
REQ-011 J encoding SHALL be: opcode 000010, target[25:0].
REQ-012 In WRITE, imem_we SHALL be 1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*count and imem_wdata = the encoded word.
REQ-013 count SHALL increment at the end of the WRITE cycle, after which the FSM SHALL return to IDLE.
REQ-014 Latency: a handshake at edge k SHALL put imem_we high in the cycle after edge k+1; throughput is one word per 3 cycles.
REQ-015 full SHALL assert when count==DEPTH; no further requests are accepted, and count SHALL never exceed DEPTH or wrap.
REQ-016 In IDLE, req_finish with req_valid low SHALL move the FSM to DONE and set done.
REQ-017 If req_valid and req_finish are both high in IDLE, the request SHALL take priority and the finish is ignored that cycle.
REQ-018 req_finish SHALL be accepted while full.
REQ-019 DONE SHALL be terminal until reset.
REQ-020 imem_addr and imem_wdata SHALL hold their last values when imem_we is 0.
REQ-021 The sticky flags (done, err_illegal) SHALL clear only on reset.

Reset
REQ-022 While rst is high, state SHALL be IDLE and imem_we, imem_addr, imem_wdata, count, full, done and err_illegal SHALL all be 0, independent of clk.
REQ-023 rst asserted mid-ENC or mid-WRITE SHALL abort the operation immediately; imem_we drops asynchronously and no partial count update occurs.
REQ-024 After rst deasserts, req_ready SHALL be 1 in the first cycle.

Verification
REQ-025 The bench SHALL cover: ADD rs=1 rt=2 rd=3 -> one imem_we pulse, addr 0x0, wdata 0x00221820, count=1.
REQ-026 The bench SHALL cover: LW rs=29 rt=8 imm=0x0004, then BEQ rs=1 rt=2 imm=0xFFFF -> wdata 0x8FA80004 at 0x0, then 0x1022FFFF at 0x4.
REQ-027 The bench SHALL cover: J target=0x0000010 -> wdata 0x08000010.
REQ-028 The bench SHALL cover: req_op=15 -> no imem_we, err_illegal=1, count unchanged, next legal request still encoded.
REQ-029 The bench SHALL cover: 64 back-to-back requests with DEPTH=64 -> last addr 0xFC, full=1, req_ready=0; a 65th request is stalled, and req_finish then sets done=1.
REQ-030 The bench SHALL cover: rst pulse during WRITE -> imem_we=0 immediately, count=0, and a new request after release writes to addr 0x0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes ADD/SUB/SLT/MUL/LW/SW/ADDI/BEQ/J requests into
// MIPS-style words and writes them sequentially into instruction memory.
// Ports: clk, rst (async, active-high); req_* request handshake and fields;
// req_finish closes the program; imem_we/imem_addr/imem_wdata write port;
// count/full word count; done/err_illegal sticky status flags.
module instr_encoder #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  input  logic          req_finish,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          done,
  output logic          err_illegal
);

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    WRITE,
    DONE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_op;
  logic [4:0]    r_rs;
  logic [4:0]    r_rt;
  logic [4:0]    r_rd;
  logic [15:0]   r_imm;
  logic [25:0]   r_target;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_count;
  logic          r_done;
  logic          r_err;

  logic [31:0]   w_word;
  logic          w_legal;
  logic [31:0]   w_addr;
  logic          w_full;
  logic          w_ready;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_ready = (r_state == IDLE) & ~w_full & ~r_done;
  assign w_addr  = BASE_ADDR + 32'({r_count, 2'b00});

  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0;
    unique case (r_op)
      4'd0: w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b100000};
      4'd1: w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b100010};
      4'd2: w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b101010};
      4'd3: w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b011100};
      4'd4: w_word = {6'b100011, r_rs, r_rt, r_imm};
      4'd5: w_word = {6'b101011, r_rs, r_rt, r_imm};
      4'd6: w_word = {6'b001000, r_rs, r_rt, r_imm};
      4'd7: w_word = {6'b000100, r_rs, r_rt, r_imm};
      4'd8: w_word = {6'b000010, r_target};
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= 4'd0;
      r_rs     <= 5'd0;
      r_rt     <= 5'd0;
      r_rd     <= 5'd0;
      r_imm    <= 16'd0;
      r_target <= 26'd0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A live request wins over a simultaneous finish.
          if (req_valid && w_ready) begin
            r_op     <= req_op;
            r_rs     <= req_rs;
            r_rt     <= req_rt;
            r_rd     <= req_rd;
            r_imm    <= req_imm;
            r_target <= req_target;
            r_state  <= ENC;
          end else if (req_finish && !req_valid) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        ENC: begin
          if (w_legal) begin
            r_we    <= 1'b1;
            r_addr  <= w_addr;
            r_wdata <= w_word;
            r_state <= WRITE;
          end else begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        WRITE: begin
          r_we    <= 1'b0;
          r_count <= r_count + CW'(1);
          r_state <= IDLE;
        end
        DONE: r_state <= DONE;
      endcase
    end
  end

  assign req_ready   = w_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign count       = r_count;
  assign full        = w_full;
  assign done        = r_done;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven vectors with a scoreboard of expected
// memory writes, plus hand sequences for illegal op, fill, finish, reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [4:0]  req_rs = 5'd0;
  logic [4:0]  req_rt = 5'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [15:0] req_imm = 16'd0;
  logic [25:0] req_target = 26'd0;
  logic        req_finish = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;
  logic        full;
  logic        done;
  logic        err_illegal;

  always #5 clk = ~clk;

  instr_encoder #(
    .DEPTH(64),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_rs(req_rs),
    .req_rt(req_rt),
    .req_rd(req_rd),
    .req_imm(req_imm),
    .req_target(req_target),
    .req_finish(req_finish),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .count(count),
    .full(full),
    .done(done),
    .err_illegal(err_illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          hs;
  } exp_t;

  vec_t tbl[10];
  vec_t ill;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", imem_addr, e.addr);
        chk("wr_data", imem_wdata, e.word);
        chk("wr_latency", 32'(cyc - e.hs), 32'd1);
      end
    end
  end

  task automatic send(input vec_t v, input bit push);
    exp_t e;
    int   n = 0;
    req_op     = v.op;
    req_rs     = v.rs;
    req_rt     = v.rt;
    req_rd     = v.rd;
    req_imm    = v.imm;
    req_target = v.tgt;
    req_valid  = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      chk("hs_timeout", 32'd0, 32'd1);
    end else if (push) begin
      e.addr = 32'(exp_n * 4);
      e.word = v.word;
      e.hs   = cyc + 1;
      sb.push_back(e);
      exp_n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    req_valid  = 1'b0;
    req_finish = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {29'd0, full, done, err_illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_n = 0;
    sb.delete();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221820};
    tbl[1] = '{4'd4, 5'd29, 5'd8,  5'd0,  16'h0004, 26'h0,       32'h8FA80004};
    tbl[2] = '{4'd7, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h1022FFFF};
    tbl[3] = '{4'd8, 5'd5,  5'd6,  5'd7,  16'h1111, 26'h0000010, 32'h08000010};
    tbl[4] = '{4'd1, 5'd4,  5'd5,  5'd6,  16'hFFFF, 26'h0,       32'h00853022};
    tbl[5] = '{4'd2, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       32'h03FFF82A};
    tbl[6] = '{4'd3, 5'd7,  5'd8,  5'd9,  16'h0000, 26'h0,       32'h00E8481C};
    tbl[7] = '{4'd5, 5'd2,  5'd3,  5'd9,  16'h1234, 26'h0,       32'hAC431234};
    tbl[8] = '{4'd6, 5'd0,  5'd1,  5'd31, 16'h8000, 26'h0,       32'h20018000};
    tbl[9] = '{4'd8, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};
    ill    = '{4'd15, 5'd1, 5'd2,  5'd3,  16'h0000, 26'h0,       32'h0};

    do_reset();
    send(tbl[0], 1'b1);
    drain();
    chk("add_count", 32'(count), 32'd1);

    do_reset();
    for (int i = 1; i <= 10; i++) send(tbl[i % 10], 1'b1);
    drain();
    chk("table_count", 32'(count), 32'd10);

    send(ill, 1'b0);
    drain();
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_count", 32'(count), 32'd10);
    send(tbl[0], 1'b1);
    drain();
    chk("post_ill_count", 32'(count), 32'd11);
    chk("err_sticky", 32'(err_illegal), 32'd1);

    req_finish = 1'b1;
    send(tbl[3], 1'b1);
    req_finish = 1'b0;
    drain();
    chk("vf_done", 32'(done), 32'd0);
    chk("vf_count", 32'(count), 32'd12);

    do_reset();
    for (int i = 0; i < 64; i++) send(tbl[i % 10], 1'b1);
    drain();
    chk("fill_count", 32'(count), 32'd64);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(req_ready), 32'd0);
    chk("fill_last_addr", imem_addr, 32'h0000_00FC);
    req_op    = 4'd0;
    req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    chk("stall_count", 32'(count), 32'd64);
    req_finish = 1'b1;
    @(negedge clk);
    req_finish = 1'b0;
    @(negedge clk);
    chk("finish_done", 32'(done), 32'd1);
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    chk("done_ready", 32'(req_ready), 32'd0);
    chk("done_count", 32'(count), 32'd64);

    do_reset();
    send(tbl[1], 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    send(tbl[0], 1'b1);
    drain();
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
